// File: rtl/devil_pkg.sv
// Shared encodings for the devil snoop-side logic: function codes, CTRL layout,
// CR response bit names and the snoop sequencer state type.
package devil_pkg;

  localparam logic [3:0] FUNC_OSH = 4'd0;
  localparam logic [3:0] FUNC_CON = 4'd1;
  localparam logic [3:0] FUNC_ADL = 4'd2;
  localparam logic [3:0] FUNC_ADT = 4'd3;
  localparam logic [3:0] FUNC_PDT = 4'd4;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_FUNC_LSB    = 4;
  localparam int CTRL_FUNC_W      = 4;
  localparam int CTRL_ACFLT_BIT   = 8;
  localparam int CTRL_ADDRFLT_BIT = 9;
  localparam int CTRL_CRRESP_LSB  = 16;

  localparam int CRRESP_DATA_TRANSFER = 0;
  localparam int CRRESP_ERROR         = 1;
  localparam int CRRESP_PASS_DIRTY    = 2;
  localparam int CRRESP_IS_SHARED     = 3;
  localparam int CRRESP_WAS_UNIQUE    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_DATA = 2'd3
  } snoop_state_e;

  // DataTransfer may only be advertised when a CD burst will actually follow.
  function automatic logic [4:0] cr_safe(input logic [4:0] resp, input logic [3:0] func);
    logic [4:0] r;
    r = resp;
    if (func != FUNC_PDT) r[CRRESP_DATA_TRANSFER] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/devil_snoop_filter.sv
// Combinational snoop match: enable AND snoop-type filter AND address-range filter.
module devil_snoop_filter #(
  parameter int ADDR_W = 44
) (
  input  logic              i_en,
  input  logic              i_acflt,
  input  logic              i_addrflt,
  input  logic [3:0]        i_cfg_snoop,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [31:0]       i_size,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [3:0]        i_snoop,
  output logic              o_match
);

  logic [ADDR_W:0] w_hi;
  logic            w_type_ok;
  logic            w_addr_ok;

  // One extra bit so a window ending at the top of the address space cannot wrap.
  assign w_hi      = {1'b0, i_base} + {{(ADDR_W+1-32){1'b0}}, i_size};
  assign w_type_ok = !i_acflt || (i_snoop == i_cfg_snoop);
  assign w_addr_ok = !i_addrflt || ((i_addr >= i_base) && ({1'b0, i_addr} < w_hi));
  assign o_match   = i_en && w_type_ok && w_addr_ok;

endmodule

// File: rtl/devil_snoop_ctrl.sv
// ACE snoop sequencer: accepts AC, classifies, waits the programmed delay,
// returns CR and, for PDT data-transfer responses, a full line of tamper data on CD.
module devil_snoop_ctrl
  import devil_pkg::*;
#(
  parameter int ADDR_W     = 44,
  parameter int DATA_W     = 128,
  parameter int LINE_BYTES = 64,
  parameter int DELAY_W    = 16,
  parameter int CNT_W      = 32
) (
  input  logic               clk_100MHz,
  input  logic               reset,
  input  logic               ctrl_en,
  input  logic [3:0]         ctrl_func,
  input  logic               ctrl_acflt,
  input  logic               ctrl_addrflt,
  input  logic [4:0]         ctrl_crresp,
  input  logic [3:0]         cfg_acsnoop,
  input  logic [ADDR_W-1:0]  cfg_base,
  input  logic [31:0]        cfg_size,
  input  logic [DELAY_W-1:0] cfg_delay,
  input  logic [DATA_W-1:0]  cfg_wdata,
  input  logic               acvalid,
  output logic               acready,
  input  logic [ADDR_W-1:0]  acaddr,
  input  logic [3:0]         acsnoop,
  output logic               crvalid,
  input  logic               crready,
  output logic [4:0]         crresp,
  output logic               cdvalid,
  input  logic               cdready,
  output logic [DATA_W-1:0]  cddata,
  output logic               cdlast,
  output logic               st_hit,
  output logic [CNT_W-1:0]   st_snoop_cnt,
  output logic [CNT_W-1:0]   st_hit_cnt
);

  localparam int BEATS  = LINE_BYTES * 8 / DATA_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  snoop_state_e       r_state, w_state_nxt;
  logic               w_match;
  logic               w_ac_hs;
  logic               w_last_beat;
  logic               r_match;
  logic               r_pdt;
  logic [4:0]         r_crresp;
  logic [DELAY_W-1:0] r_cnt;
  logic [DATA_W-1:0]  r_wdata;
  logic [BEAT_W-1:0]  r_beat;
  logic [CNT_W-1:0]   r_snoop_cnt;
  logic [CNT_W-1:0]   r_hit_cnt;

  devil_snoop_filter #(.ADDR_W(ADDR_W)) u_filter (
    .i_en        (ctrl_en),
    .i_acflt     (ctrl_acflt),
    .i_addrflt   (ctrl_addrflt),
    .i_cfg_snoop (cfg_acsnoop),
    .i_base      (cfg_base),
    .i_size      (cfg_size),
    .i_addr      (acaddr),
    .i_snoop     (acsnoop),
    .o_match     (w_match)
  );

  assign acready     = (r_state == ST_IDLE) && !reset;
  assign w_ac_hs     = acvalid && acready;
  assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));

  always_ff @(posedge clk_100MHz) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    crvalid     = 1'b0;
    crresp      = '0;
    cdvalid     = 1'b0;
    cddata      = '0;
    cdlast      = 1'b0;
    st_hit      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_ac_hs) w_state_nxt = (w_match && (cfg_delay != '0)) ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: begin
        if (r_cnt == DELAY_W'(1)) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        crvalid = 1'b1;
        crresp  = r_crresp;
        if (crready) begin
          w_state_nxt = r_pdt ? ST_DATA : ST_IDLE;
          st_hit      = r_match && !r_pdt && !reset;
        end
      end
      ST_DATA: begin
        cdvalid = 1'b1;
        cddata  = r_wdata;
        cdlast  = w_last_beat;
        if (cdready && w_last_beat) begin
          w_state_nxt = ST_IDLE;
          st_hit      = !reset;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Everything the transaction needs is frozen at the AC handshake, including the
  // match outcome itself, so later config writes cannot reach it.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_match  <= 1'b0;
      r_pdt    <= 1'b0;
      r_crresp <= '0;
      r_cnt    <= '0;
      r_wdata  <= '0;
      r_beat   <= '0;
    end else begin
      if (w_ac_hs) begin
        r_match  <= w_match;
        r_pdt    <= w_match && ctrl_crresp[CRRESP_DATA_TRANSFER] && (ctrl_func == FUNC_PDT);
        r_crresp <= w_match ? cr_safe(ctrl_crresp, ctrl_func) : 5'b0;
        r_cnt    <= cfg_delay;
        r_wdata  <= cfg_wdata;
        r_beat   <= '0;
      end else begin
        if (r_state == ST_WAIT) r_cnt <= r_cnt - DELAY_W'(1);
        if (cdvalid && cdready) r_beat <= r_beat + BEAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_snoop_cnt <= '0;
      r_hit_cnt   <= '0;
    end else if (w_ac_hs) begin
      if (r_snoop_cnt != '1)          r_snoop_cnt <= r_snoop_cnt + CNT_W'(1);
      if (w_match && r_hit_cnt != '1) r_hit_cnt   <= r_hit_cnt + CNT_W'(1);
    end
  end

  assign st_snoop_cnt = r_snoop_cnt;
  assign st_hit_cnt   = r_hit_cnt;

endmodule

// File: tb/tb_devil_snoop_ctrl.sv
// Directed bench for devil_snoop_ctrl: vector table of single snoops plus
// hand-written stall, mid-transaction reset and snapshot sequences.
module tb_devil_snoop_ctrl;
  import devil_pkg::*;

  localparam logic [127:0] W = 128'h00000002_FFFFFFFF_00000001_F0F0F0F0;

  typedef struct {
    logic        en;
    logic [3:0]  func;
    logic        acflt;
    logic        addrflt;
    logic [4:0]  crr;
    logic [3:0]  cfg_snoop;
    logic [43:0] base;
    logic [31:0] size;
    logic [15:0] delay;
    logic [43:0] addr;
    logic [3:0]  snoop;
    logic [4:0]  exp_crresp;
    logic        exp_cd;
    logic        exp_hit;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         ctrl_en, ctrl_acflt, ctrl_addrflt;
  logic [3:0]   ctrl_func, cfg_acsnoop, acsnoop;
  logic [4:0]   ctrl_crresp, crresp;
  logic [43:0]  cfg_base, acaddr;
  logic [31:0]  cfg_size, st_snoop_cnt, st_hit_cnt;
  logic [15:0]  cfg_delay;
  logic [127:0] cfg_wdata, cddata;
  logic         acvalid, acready, crvalid, crready, cdvalid, cdready, cdlast, st_hit;

  int checks = 0;
  int errors = 0;
  int m_snoops = 0;
  int m_hits = 0;
  vec_t vecs[13];

  always #5 clk = ~clk;

  devil_snoop_ctrl dut (
    .clk_100MHz(clk), .reset(reset),
    .ctrl_en(ctrl_en), .ctrl_func(ctrl_func), .ctrl_acflt(ctrl_acflt),
    .ctrl_addrflt(ctrl_addrflt), .ctrl_crresp(ctrl_crresp),
    .cfg_acsnoop(cfg_acsnoop), .cfg_base(cfg_base), .cfg_size(cfg_size),
    .cfg_delay(cfg_delay), .cfg_wdata(cfg_wdata),
    .acvalid(acvalid), .acready(acready), .acaddr(acaddr), .acsnoop(acsnoop),
    .crvalid(crvalid), .crready(crready), .crresp(crresp),
    .cdvalid(cdvalid), .cdready(cdready), .cddata(cddata), .cdlast(cdlast),
    .st_hit(st_hit), .st_snoop_cnt(st_snoop_cnt), .st_hit_cnt(st_hit_cnt)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic en, input logic [3:0] func, input logic acflt,
                              input logic addrflt, input logic [4:0] crr, input logic [3:0] cfg_snoop,
                              input logic [43:0] base, input logic [31:0] size, input logic [15:0] delay,
                              input logic [43:0] addr, input logic [3:0] snoop,
                              input logic [4:0] exp_crresp, input logic exp_cd, input logic exp_hit);
    vec_t v;
    v.en = en; v.func = func; v.acflt = acflt; v.addrflt = addrflt; v.crr = crr;
    v.cfg_snoop = cfg_snoop; v.base = base; v.size = size; v.delay = delay;
    v.addr = addr; v.snoop = snoop; v.exp_crresp = exp_crresp; v.exp_cd = exp_cd; v.exp_hit = exp_hit;
    return v;
  endfunction

  task automatic apply_cfg(input vec_t v);
    ctrl_en = v.en; ctrl_func = v.func; ctrl_acflt = v.acflt; ctrl_addrflt = v.addrflt;
    ctrl_crresp = v.crr; cfg_acsnoop = v.cfg_snoop; cfg_base = v.base; cfg_size = v.size;
    cfg_delay = v.delay; cfg_wdata = W; acaddr = v.addr; acsnoop = v.snoop;
  endtask

  task automatic ac_handshake();
    int g;
    acvalid = 1'b1;
    g = 0;
    while (!acready && g < 20) begin tick(); g++; end
    chk("acready_wait", acready, 1'b1);
    tick();
    acvalid = 1'b0;
  endtask

  // Config is scrambled right after the AC handshake; the transaction must not notice.
  task automatic run_snoop(input string tag, input vec_t v, input int cr_hold, input bit cd_toggle);
    int n;
    int b;
    int g;
    bit phase;
    apply_cfg(v);
    ac_handshake();
    ctrl_en = 1'b0; ctrl_crresp = ~v.crr; cfg_delay = 16'hFFFF; cfg_wdata = ~W;
    ctrl_func = FUNC_OSH; ctrl_acflt = ~v.acflt; ctrl_addrflt = ~v.addrflt;
    n = 1;
    while (!crvalid && n < 100) begin tick(); n++; end
    chk({tag, "_cr_latency"}, 128'(n), v.exp_hit ? 128'(1 + v.delay) : 128'd1);
    for (int k = 0; k < cr_hold; k++) begin
      chk({tag, "_cr_hold_valid"}, crvalid, 1'b1);
      chk({tag, "_cr_hold_resp"}, crresp, v.exp_crresp);
      tick();
    end
    chk({tag, "_crresp"}, crresp, v.exp_crresp);
    chk({tag, "_cd_idle_in_resp"}, cdvalid, 1'b0);
    crready = 1'b1;
    #1;
    chk({tag, "_hit_on_cr"}, st_hit, v.exp_hit && !v.exp_cd);
    tick();
    crready = 1'b0;
    if (v.exp_cd) begin
      b = 0; g = 0; phase = 1'b0;
      while (b < 4 && g < 50) begin
        chk({tag, "_cdvalid"}, cdvalid, 1'b1);
        chk({tag, "_cddata"}, cddata, W);
        chk({tag, "_cdlast"}, cdlast, b == 3);
        cdready = cd_toggle ? phase : 1'b1;
        #1;
        chk({tag, "_hit_on_cd"}, st_hit, cdready && b == 3);
        if (cdready) b++;
        tick();
        phase = ~phase;
        g++;
      end
      cdready = 1'b0;
      chk({tag, "_cd_beats"}, 128'(b), 128'd4);
    end
    chk({tag, "_cd_done"}, cdvalid, 1'b0);
    chk({tag, "_back_to_idle"}, acready, 1'b1);
    m_snoops++;
    if (v.exp_hit) m_hits++;
    chk({tag, "_snoop_cnt"}, st_snoop_cnt, 128'(m_snoops));
    chk({tag, "_hit_cnt"}, st_hit_cnt, 128'(m_hits));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_acready"}, acready, 1'b0);
    chk({tag, "_crvalid"}, crvalid, 1'b0);
    chk({tag, "_cdvalid"}, cdvalid, 1'b0);
    chk({tag, "_crresp"}, crresp, 5'd0);
    chk({tag, "_cddata"}, cddata, 128'd0);
    chk({tag, "_cdlast"}, cdlast, 1'b0);
    chk({tag, "_st_hit"}, st_hit, 1'b0);
    chk({tag, "_snoop_cnt"}, st_snoop_cnt, 32'd0);
    chk({tag, "_hit_cnt"}, st_hit_cnt, 32'd0);
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    tick();
    chk_reset_state(tag);
    reset = 1'b0;
    m_snoops = 0;
    m_hits = 0;
    tick();
    chk({tag, "_acready_after"}, acready, 1'b1);
    chk({tag, "_snoop_cnt_after"}, st_snoop_cnt, 32'd0);
  endtask

  initial begin
    vec_t v;
    //              en func     acf adf crr    csn  base              size   dly    addr              snp   exp    cd   hit
    vecs[0]  = mk(1, FUNC_PDT, 0, 0, 5'h01, 4'd0, 44'h0,            32'd0, 16'd0, 44'h0_4000_0000, 4'd0, 5'h01, 1, 1);
    vecs[1]  = mk(1, FUNC_PDT, 1, 0, 5'h01, 4'd1, 44'h0,            32'd0, 16'd0, 44'h0_4000_0000, 4'd0, 5'h00, 0, 0);
    vecs[2]  = mk(1, FUNC_PDT, 1, 0, 5'h01, 4'd1, 44'h0,            32'd0, 16'd0, 44'h0_4000_0000, 4'd1, 5'h01, 1, 1);
    vecs[3]  = mk(1, FUNC_PDT, 0, 1, 5'h08, 4'd0, 44'h0_4000_0000,  32'd4, 16'd0, 44'h0_4000_0003, 4'd0, 5'h08, 0, 1);
    vecs[4]  = mk(1, FUNC_PDT, 0, 1, 5'h08, 4'd0, 44'h0_4000_0000,  32'd4, 16'd0, 44'h0_4000_0004, 4'd0, 5'h00, 0, 0);
    vecs[5]  = mk(1, FUNC_PDT, 0, 1, 5'h08, 4'd0, 44'h0_4000_0000,  32'd4, 16'd0, 44'h0_3FFF_FFFF, 4'd0, 5'h00, 0, 0);
    vecs[6]  = mk(1, FUNC_PDT, 0, 1, 5'h01, 4'd0, 44'h0_4000_0000,  32'd0, 16'd0, 44'h0_4000_0000, 4'd0, 5'h00, 0, 0);
    vecs[7]  = mk(1, FUNC_ADT, 0, 0, 5'h09, 4'd0, 44'h0,            32'd0, 16'd0, 44'h0_1000_0000, 4'd0, 5'h08, 0, 1);
    vecs[8]  = mk(0, FUNC_PDT, 0, 0, 5'h01, 4'd0, 44'h0,            32'd0, 16'd0, 44'h0_4000_0000, 4'd0, 5'h00, 0, 0);
    vecs[9]  = mk(1, FUNC_PDT, 0, 0, 5'h10, 4'd0, 44'h0,            32'd0, 16'd3, 44'h0_4000_0000, 4'd0, 5'h10, 0, 1);
    vecs[10] = mk(1, FUNC_PDT, 0, 1, 5'h01, 4'd0, 44'hFFF_FFFF_FFFC, 32'd8, 16'd0, 44'hFFF_FFFF_FFFF, 4'd0, 5'h01, 1, 1);
    vecs[11] = mk(1, FUNC_PDT, 1, 0, 5'h01, 4'd7, 44'h0,            32'd0, 16'd2, 44'h0_4000_0000, 4'd2, 5'h00, 0, 0);
    vecs[12] = mk(1, FUNC_PDT, 0, 0, 5'h05, 4'd0, 44'h0,            32'd0, 16'd1, 44'h0_4000_0000, 4'd0, 5'h05, 1, 1);

    reset = 1'b1; acvalid = 1'b0; crready = 1'b0; cdready = 1'b0;
    apply_cfg(vecs[0]);
    repeat (3) tick();
    chk_reset_state("reset");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) run_snoop($sformatf("vec%0d", i), vecs[i], 0, 1'b0);

    // CR stall: delay 5, crready withheld three cycles after crvalid.
    v = mk(1, FUNC_PDT, 0, 0, 5'h08, 4'd0, 44'h0, 32'd0, 16'd5, 44'h0_4000_0000, 4'd0, 5'h08, 0, 1);
    run_snoop("crstall", v, 3, 1'b0);

    // CD backpressure with ctrl_en and cfg_wdata rewritten mid-transaction.
    v = mk(1, FUNC_PDT, 0, 0, 5'h01, 4'd0, 44'h0, 32'd0, 16'd2, 44'h0_4000_0000, 4'd0, 5'h01, 1, 1);
    run_snoop("cdtoggle", v, 0, 1'b1);

    // Reset while waiting out the CR delay.
    v = mk(1, FUNC_PDT, 0, 0, 5'h01, 4'd0, 44'h0, 32'd0, 16'd10, 44'h0_4000_0000, 4'd0, 5'h01, 1, 1);
    apply_cfg(v);
    ac_handshake();
    tick();
    chk("wait_no_crvalid", crvalid, 1'b0);
    chk("wait_no_acready", acready, 1'b0);
    pulse_reset("rst_wait");

    // Reset in the middle of a CD burst.
    apply_cfg(vecs[0]);
    ac_handshake();
    chk("data_crvalid", crvalid, 1'b1);
    crready = 1'b1;
    tick();
    crready = 1'b0;
    cdready = 1'b1;
    tick();
    cdready = 1'b0;
    chk("data_mid_cdvalid", cdvalid, 1'b1);
    chk("data_mid_cdlast", cdlast, 1'b0);
    pulse_reset("rst_data");

    run_snoop("post_reset", vecs[0], 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
